// File: rtl/rs_tdp36k_pkg.sv
// Shared constants for the RS_TDP36K FIFO-mode core: width codes, flag bit map, geometry helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rs_tdp36k_pkg;

  // Total usable bits in one 36 Kbit block RAM (parity bits included).
  localparam int RAM_BITS = 36864;

  // Occupancy counter width; wide enough to hold depth 4096 at width 9.
  localparam int COUNT_W = 13;

  // Width encodings as used by the TDP36K configuration bus.
  localparam logic [2:0] WCODE_36 = 3'b110;
  localparam logic [2:0] WCODE_18 = 3'b010;
  localparam logic [2:0] WCODE_9  = 3'b100;

  // Bit positions of the status flags on RDATA_A1, matching the FIFO36K unpacking.
  localparam int FLAG_OVERFLOW     = 0;
  localparam int FLAG_PROG_FULL    = 1;
  localparam int FLAG_ALMOST_FULL  = 2;
  localparam int FLAG_FULL         = 3;
  localparam int FLAG_UNDERFLOW    = 4;
  localparam int FLAG_PROG_EMPTY   = 5;
  localparam int FLAG_ALMOST_EMPTY = 6;
  localparam int FLAG_EMPTY        = 7;

  // Number of words the RAM holds at a given word width.
  function automatic int fifo_depth(input int data_width);
    return RAM_BITS / data_width;
  endfunction

  // Address width needed to index fifo_depth() words.
  function automatic int fifo_addr_w(input int data_width);
    return $clog2(RAM_BITS / data_width);
  endfunction

  // Map a word width onto its configuration code; unsupported widths give 3'b000.
  function automatic logic [2:0] width_code(input int data_width);
    case (data_width)
      36:      return WCODE_36;
      18:      return WCODE_18;
      9:       return WCODE_9;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rs_tdp36k_ram.sv
// Simple dual-port storage array: one synchronous write port, one registered read port.
// Latency: write lands at the edge; read data registered one edge after rd_en.
// Backpressure: none; the caller only enables ports for accepted transfers.
module rs_tdp36k_ram #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  // Array contents are never reset; only the output register is.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on the accepting edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Read port: output register updates only on an accepted read, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rs_tdp36k_fifo.sv
// Single-clock FIFO on a 36 Kbit TDP RAM; flags returned on RDATA_A1 (optional error flags: RS_TDP36K_ERR_FLAGS_EN).
// Latency: write visible to a read sampled one edge later; read data valid one edge after an accepted REN_B1.
// Backpressure: writes dropped while FULL, reads ignored while EMPTY (OVERFLOW/UNDERFLOW pulse when enabled).
module rs_tdp36k_fifo
  import rs_tdp36k_pkg::*;
#(
  parameter int          DATA_WIDTH        = 36,
  parameter logic [11:0] PROG_FULL_THRESH  = 12'hFFA,
  parameter logic [11:0] PROG_EMPTY_THRESH = 12'h004
) (
  input  logic        CLK_A1,
  input  logic        FLUSH1,
  input  logic        WEN_A1,
  input  logic [17:0] WDATA_A1,
  input  logic [17:0] WDATA_A2,
  input  logic        REN_B1,
  output logic [17:0] RDATA_B1,
  output logic [17:0] RDATA_B2,
  output logic [17:0] RDATA_A1
);

  localparam int               DEPTH   = fifo_depth(DATA_WIDTH);
  localparam int               ADDR_W  = fifo_addr_w(DATA_WIDTH);
  localparam logic [2:0]       WCODE   = width_code(DATA_WIDTH);
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [COUNT_W-1:0]    count;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [DATA_WIDTH-1:0] rd_dat;

  logic empty;
  logic almost_empty;
  logic prog_empty;
  logic full;
  logic almost_full;
  logic prog_full;
  logic overflow;
  logic underflow;
  logic wr_acc;
  logic rd_acc;

  // Status decoded straight from the registered count, so flags move with it.
  assign empty        = (count == '0);
  assign almost_empty = (count == COUNT_W'(1));
  assign prog_empty   = (count <= {1'b0, PROG_EMPTY_THRESH});
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count == DEPTH_C - COUNT_W'(1));
  assign prog_full    = (count >= {1'b0, PROG_FULL_THRESH});

  // Accept decisions use the flags as they stood before the edge.
  assign wr_acc = WEN_A1 && !full;
  assign rd_acc = REN_B1 && !empty;

  // Lane mapping: active bits stored as-is, unused read bits forced to zero.
  generate
    if (WCODE == WCODE_36) begin : g_w36
      assign wr_dat   = {WDATA_A2, WDATA_A1};
      assign RDATA_B1 = rd_dat[17:0];
      assign RDATA_B2 = rd_dat[35:18];
    end else if (WCODE == WCODE_18) begin : g_w18
      assign wr_dat   = WDATA_A1;
      assign RDATA_B1 = rd_dat;
      assign RDATA_B2 = '0;
    end else begin : g_w9
      assign wr_dat   = {WDATA_A1[16], WDATA_A1[7:0]};
      assign RDATA_B1 = {1'b0, rd_dat[8], 8'h00, rd_dat[7:0]};
      assign RDATA_B2 = '0;
    end
  endgenerate

  rs_tdp36k_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (CLK_A1),
    .rst_n   (FLUSH1),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_dat  (wr_dat),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_dat  (rd_dat)
  );

  // Pointers advance on accepted transfers and wrap naturally at the power-of-two depth;
  // the count only moves when exactly one side is accepted.
  always_ff @(posedge CLK_A1 or negedge FLUSH1) begin
    if (!FLUSH1) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + COUNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - COUNT_W'(1);
      end
    end
  end

`ifdef RS_TDP36K_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // One-cycle pulses flagging a request that arrived while the FIFO could not take it.
  always_ff @(posedge CLK_A1 or negedge FLUSH1) begin
    if (!FLUSH1) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= WEN_A1 && full;
      underflow_q <= REN_B1 && empty;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // Pack the flag vector in the order the FIFO36K wrapper expects; upper bits stay zero.
  always_comb begin
    RDATA_A1                    = '0;
    RDATA_A1[FLAG_OVERFLOW]     = overflow;
    RDATA_A1[FLAG_PROG_FULL]    = prog_full;
    RDATA_A1[FLAG_ALMOST_FULL]  = almost_full;
    RDATA_A1[FLAG_FULL]         = full;
    RDATA_A1[FLAG_UNDERFLOW]    = underflow;
    RDATA_A1[FLAG_PROG_EMPTY]   = prog_empty;
    RDATA_A1[FLAG_ALMOST_EMPTY] = almost_empty;
    RDATA_A1[FLAG_EMPTY]        = empty;
  end

endmodule

// File: tb/tb_rs_tdp36k_fifo.sv
// Directed bench for rs_tdp36k_fifo: width 36 (default and low PROG_FULL threshold) and width 9.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: full/empty rejection and error pulses exercised directly.
module tb_rs_tdp36k_fifo;

`ifdef RS_TDP36K_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen;
  logic        ren;
  logic        wen9;
  logic        ren9;
  logic [17:0] wd1;
  logic [17:0] wd2;
  logic [17:0] a_rd1, a_rd2, a_fl;
  logic [17:0] p_rd1, p_rd2, p_fl;
  logic [17:0] n_rd1, n_rd2, n_fl;
  logic [35:0] w;
  logic [17:0] uf_exp;
  logic [17:0] of_exp;
  logic [17:0] uf_w_exp;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  rs_tdp36k_fifo #(.DATA_WIDTH(36)) u_a (
    .CLK_A1(clk), .FLUSH1(rst_n), .WEN_A1(wen), .WDATA_A1(wd1), .WDATA_A2(wd2),
    .REN_B1(ren), .RDATA_B1(a_rd1), .RDATA_B2(a_rd2), .RDATA_A1(a_fl)
  );

  rs_tdp36k_fifo #(.DATA_WIDTH(36), .PROG_FULL_THRESH(12'd1000)) u_p (
    .CLK_A1(clk), .FLUSH1(rst_n), .WEN_A1(wen), .WDATA_A1(wd1), .WDATA_A2(wd2),
    .REN_B1(ren), .RDATA_B1(p_rd1), .RDATA_B2(p_rd2), .RDATA_A1(p_fl)
  );

  rs_tdp36k_fifo #(.DATA_WIDTH(9)) u_n (
    .CLK_A1(clk), .FLUSH1(rst_n), .WEN_A1(wen9), .WDATA_A1(wd1), .WDATA_A2(wd2),
    .REN_B1(ren9), .RDATA_B1(n_rd1), .RDATA_B2(n_rd2), .RDATA_A1(n_fl)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] pat(input int k);
    return 36'h500000000 | 36'(k) | (36'(k) << 18);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    uf_exp   = ERR_EN ? 18'h0B0 : 18'h0A0;
    of_exp   = ERR_EN ? 18'h009 : 18'h008;
    uf_w_exp = ERR_EN ? 18'h070 : 18'h060;
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0; wen9 = 1'b0; ren9 = 1'b0;
    wd1 = '0; wd2 = '0;
    #2;
    chk("rst_flags", 36'(a_fl), 36'h0A0);
    chk("rst_rdata", {a_rd2, a_rd1}, 36'h0);
    chk("rst_flags9", 36'(n_fl), 36'h0A0);
    #20;
    rst_n = 1'b1;
    tick();
    chk("idle_flags", 36'(a_fl), 36'h0A0);
    chk("idle_rdata", {a_rd2, a_rd1}, 36'h0);

    // Single word through width 36.
    w = 36'h912345678;
    {wd2, wd1} = w;
    wen = 1'b1;
    tick();
    wen = 1'b0;
    chk("one_word_flags", 36'(a_fl), 36'h060);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("one_word_rdata", {a_rd2, a_rd1}, w);
    chk("one_word_empty", 36'(a_fl), 36'h0A0);

    // Fill to 1024; count after iteration k is k+1.
    wen = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      {wd2, wd1} = pat(k);
      tick();
      if (k == 998) chk("pf_at_999", 36'(p_fl[1]), 36'h0);
      if (k == 999) chk("pf_at_1000", 36'(p_fl[1]), 36'h1);
      if (k == 1022) begin
        chk("af_flags_a", 36'(a_fl), 36'h004);
        chk("af_flags_p", 36'(p_fl), 36'h006);
      end
    end
    chk("full_flags_a", 36'(a_fl), 36'h008);
    chk("full_flags_p", 36'(p_fl), 36'h00A);

    // Write while full is dropped.
    {wd2, wd1} = 36'hFFFFFFFFF;
    tick();
    wen = 1'b0;
    chk("ovf_pulse", 36'(a_fl), 36'(of_exp));
    tick();
    chk("ovf_clear", 36'(a_fl), 36'h008);

    // Drain; count after iteration k is 1023-k.
    ren = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      tick();
      chk("drain_data", {a_rd2, a_rd1}, pat(k));
      if (k == 1018) chk("cnt5_flags", 36'(a_fl), 36'h000);
      if (k == 1019) chk("cnt4_flags", 36'(a_fl), 36'h020);
      if (k == 1022) chk("cnt1_flags", 36'(a_fl), 36'h060);
    end
    chk("drained_flags", 36'(a_fl), 36'h0A0);
    chk("drain_data_p", {p_rd2, p_rd1}, pat(1023));

    // Read while empty: data holds, underflow pulses.
    tick();
    ren = 1'b0;
    chk("uf_pulse", 36'(a_fl), 36'(uf_exp));
    chk("uf_hold", {a_rd2, a_rd1}, pat(1023));
    tick();
    chk("uf_clear", 36'(a_fl), 36'h0A0);

    // Simultaneous read+write at count 5.
    wen = 1'b1;
    for (int k = 0; k < 5; k++) begin
      {wd2, wd1} = pat(100 + k);
      tick();
    end
    chk("rw_pre_flags", 36'(a_fl), 36'h000);
    ren = 1'b1;
    for (int k = 0; k < 3; k++) begin
      {wd2, wd1} = pat(105 + k);
      tick();
      chk("rw_data", {a_rd2, a_rd1}, pat(100 + k));
      chk("rw_cnt5", 36'(a_fl), 36'h000);
    end
    wen = 1'b0;
    for (int k = 3; k < 8; k++) begin
      tick();
      chk("rw_drain", {a_rd2, a_rd1}, pat(100 + k));
    end
    chk("rw_empty", 36'(a_fl), 36'h0A0);

    // Simultaneous read+write while empty: write only.
    wen = 1'b1;
    {wd2, wd1} = pat(200);
    tick();
    wen = 1'b0;
    chk("rw_empty_flags", 36'(a_fl), 36'(uf_w_exp));
    chk("rw_empty_hold", {a_rd2, a_rd1}, pat(107));
    tick();
    ren = 1'b0;
    chk("rw_empty_data", {a_rd2, a_rd1}, pat(200));
    chk("rw_empty_end", 36'(a_fl), 36'h0A0);

    // Width 9 lane mapping.
    wd1 = 18'h3FFA5;
    wd2 = 18'h3FFFF;
    wen9 = 1'b1;
    tick();
    wen9 = 1'b0;
    chk("w9_flags", 36'(n_fl), 36'h060);
    ren9 = 1'b1;
    tick();
    ren9 = 1'b0;
    chk("w9_rd1", 36'(n_rd1), 36'h100A5);
    chk("w9_rd2", 36'(n_rd2), 36'h0);
    chk("w9_empty", 36'(n_fl), 36'h0A0);

    // Flush mid-stream: words discarded, EMPTY immediate.
    wen9 = 1'b1;
    wd1 = 18'h00011;
    tick();
    wd1 = 18'h00022;
    tick();
    wen9 = 1'b0;
    chk("w9_cnt2", 36'(n_fl), 36'h020);
    #3;
    rst_n = 1'b0;
    #1;
    chk("flush_empty9", 36'(n_fl), 36'h0A0);
    chk("flush_rdata9", 36'(n_rd1), 36'h0);
    chk("flush_empty36", 36'(a_fl), 36'h0A0);
    #2;
    rst_n = 1'b1;
    wd1 = 18'h10033;
    wen9 = 1'b1;
    ren9 = 1'b1;
    tick();
    wen9 = 1'b0;
    chk("post_flush_flags", 36'(n_fl), 36'(uf_w_exp));
    chk("post_flush_hold", 36'(n_rd1), 36'h0);
    tick();
    ren9 = 1'b0;
    chk("post_flush_data", 36'(n_rd1), 36'h10033);
    chk("post_flush_empty", 36'(n_fl), 36'h0A0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
